// File: rtl/wb_block_copier.sv
// wb_block_copier: Wishbone pipelined master that copies a block of words
// between two regions of a dual-port RAM, one word (read then write) at a time.
module wb_block_copier #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [AW-1:0] src_addr_i,
    input  logic [AW-1:0] dst_addr_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   words_done_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [3:0]    wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    input  logic [DW-1:0] wb_data_i,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] srcPtr;
    logic [AW-1:0] dstPtr;
    logic [AW:0]   lenReg;
    logic [AW:0]   clampedLen;
    logic [AW:0]   nextCount;
    logic [AW-1:0] nextSrc;

    // Length clamp and next-word arithmetic (pointers wrap modulo 2^AW)
    always_comb begin
        clampedLen = (len_i > MAX_LEN) ? MAX_LEN : len_i;
        nextCount  = words_done_o + (AW+1)'(1);
        nextSrc    = srcPtr + AW'(1);
    end

    // Copy sequencer; every bus and status output is registered here.
    // wb_data_o doubles as the holding register for the word just read.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            srcPtr       <= '0;
            dstPtr       <= '0;
            lenReg       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            words_done_o <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= '0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        srcPtr       <= src_addr_i;
                        dstPtr       <= dst_addr_i;
                        lenReg       <= clampedLen;
                        words_done_o <= '0;
                        busy_o       <= 1'b1;
                        if (clampedLen == '0) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            wb_we_o   <= '0;
                            wb_addr_o <= src_addr_i;
                            state     <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wb_ack_i) begin
                        wb_data_o <= wb_data_i;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= '1;
                        wb_addr_o <= dstPtr;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wb_ack_i) begin
                        words_done_o <= nextCount;
                        srcPtr       <= nextSrc;
                        dstPtr       <= dstPtr + AW'(1);
                        if (nextCount == lenReg) begin
                            wb_cyc_o <= 1'b0;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            wb_stb_o  <= 1'b1;
                            wb_we_o   <= '0;
                            wb_addr_o <= nextSrc;
                            state     <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
